// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and sizing helpers for the data-memory arbiter and
//            its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  // Arbiter transaction state: IDLE accepts a request, BUSY holds it on memory.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 32;

  // Index width for an n-way pick; never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-mask width for a data bus.
  function automatic int mask_w(input int data_w);
    return data_w / 8;
  endfunction

  localparam int ARB_IDX_W = arb_idx_w(NUM_REQ_DEF);
  localparam int MASK_W    = mask_w(DATA_W_DEF);

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Stateless round-robin pick. Searches the valid vector starting
//            one past the last grant, wrapping, and returns the first hit as
//            a one-hot grant plus its encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in priority order; the first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one data-memory port between NUM_REQ harts. One
//            transaction is outstanding at a time; the accepted request is
//            latched and held on the memory port until i_mem_done, then the
//            owner receives a one-cycle response pulse with the load data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ-1:0]          i_req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] i_req_mask,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_rdata,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic                        o_mem_ren,
  output logic                        o_mem_wen,
  output logic [DATA_W-1:0]           o_mem_wdata,
  output logic [DATA_W/8-1:0]         o_mem_mask,
  input  logic                        i_mem_done,
  input  logic [DATA_W-1:0]           i_mem_rdata
);

  localparam int IDX_W = arb_idx_w(NUM_REQ);
  localparam int MW    = mask_w(DATA_W);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   gidx_q;
  logic               wen_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MW-1:0]      mask_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] req_ready;
  logic               accept;
  logic               complete;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid_i (i_req_valid),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign accept   = (state_q == ST_IDLE) && arb_any;
  assign complete = (state_q == ST_BUSY) && i_mem_done;

  // Next-state and combinational ready: a grant is only offered while idle.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_mem_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, round-robin pointer and registered response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gidx_q      <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (accept) begin
        gidx_q  <= arb_idx;
        wen_q   <= i_req_wen[arb_idx];
        addr_q  <= i_req_addr[arb_idx*ADDR_W +: ADDR_W];
        wdata_q <= i_req_wdata[arb_idx*DATA_W +: DATA_W];
        mask_q  <= i_req_mask[arb_idx*MW +: MW];
      end
      if (complete) begin
        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;
        rdata_q     <= wen_q ? '0 : i_mem_rdata;
        last_q      <= gidx_q;
      end
    end
  end

  assign o_req_ready = req_ready;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;
  assign o_mem_ren   = (state_q == ST_BUSY) && !wen_q;
  assign o_mem_wen   = (state_q == ST_BUSY) && wen_q;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a scoreboard of
//            expected responses and a small latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wen   = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_mask  = '0;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_ren;
  logic            o_mem_wen;
  logic [DW-1:0]   o_mem_wdata;
  logic [3:0]      o_mem_mask;
  logic            mem_done  = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          mem_waits = 0;
  int          wcnt = 0;
  logic        noise = 1'b0;
  logic        mem_fixed_en = 1'b0;
  logic [31:0] mem_fixed = '0;

  typedef struct {
    logic [N-1:0] onehot;
    logic [31:0]  rdata;
    int           at;
  } exp_t;
  exp_t sbq[$];

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_wen   (req_wen),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_mask  (req_mask),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ren   (o_mem_ren),
    .o_mem_wen   (o_mem_wen),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_mask  (o_mem_mask),
    .i_mem_done  (mem_done),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int k, input logic wen, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    req_valid[k]          = 1'b1;
    req_wen[k]            = wen;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
    req_mask[k*4 +: 4]    = m;
  endtask

  task automatic clr_req(input int k);
    req_valid[k] = 1'b0;
  endtask

  task automatic push(input logic [N-1:0] oh, input logic [31:0] rd, input int at);
    exp_t e;
    e.onehot = oh;
    e.rdata  = rd;
    e.at     = at;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  // Memory model: completes after mem_waits extra cycles; load data is
  // either a fixed word or the address XOR 0x5A5A0000.
  initial forever begin
    @(negedge clk);
    if (o_mem_ren || o_mem_wen) begin
      if (wcnt == mem_waits) begin
        mem_done  = 1'b1;
        mem_rdata = mem_fixed_en ? mem_fixed : (o_mem_addr ^ 32'h5A5A_0000);
        wcnt      = 0;
      end else begin
        mem_done  = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        wcnt++;
      end
    end else begin
      mem_done  = noise;
      mem_rdata = noise ? 32'h0BAD_0BAD : 32'h0;
      wcnt      = 0;
    end
  end

  // Monitor: every response pulse is matched against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (o_mem_ren || o_mem_wen)
      chk("mem_en_exclusive", 64'(o_mem_ren & o_mem_wen), 64'd0);
    if (o_rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid 0x%0h, expected none (cycle %0d)", o_rsp_valid, cyc);
      end else begin
        e = sbq.pop_front();
        chk("rsp_owner", 64'(o_rsp_valid), 64'(e.onehot));
        chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e.rdata));
        chk("rsp_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  logic [N-1:0] cont_grant [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [31:0]  cont_rdata [3] = '{32'h5A5A_0010, 32'h5A5A_0020, 32'h5A5A_0030};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({o_req_ready, o_rsp_valid, o_mem_ren, o_mem_wen}), 64'd0);
    chk("reset_addr", 64'(o_mem_addr), 64'd0);
    chk("reset_wdata", 64'(o_mem_wdata), 64'd0);
    chk("reset_mask_rdata", 64'({o_mem_mask, o_rsp_rdata}), 64'd0);
    rst = 1'b0;

    // Single load, zero-wait memory
    @(negedge clk);
    mem_fixed_en = 1'b1;
    mem_fixed    = 32'hDEAD_BEEF;
    mem_waits    = 0;
    set_req(1, 1'b0, 32'h100, 32'h0, 4'hF);
    #1 chk("load_ready", 64'(o_req_ready), 64'b010);
    push(3'b010, 32'hDEAD_BEEF, cyc + 2);
    @(negedge clk);
    clr_req(1);
    chk("load_mem_port", 64'({o_mem_ren, o_mem_wen, o_mem_addr}), {30'd0, 2'b10, 32'h100});
    wait_drain();

    // Byte store with three wait states
    @(negedge clk);
    mem_waits = 3;
    set_req(2, 1'b1, 32'h2000, 32'hAB00_0000, 4'b1000);
    #1 chk("store_ready", 64'(o_req_ready), 64'b100);
    push(3'b100, 32'h0, cyc + 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) clr_req(2);
      chk("store_ctrl_hold", 64'({o_mem_ren, o_mem_wen, o_mem_mask}), 64'b01_1000);
      chk("store_payload_hold", {o_mem_addr, o_mem_wdata}, {32'h2000, 32'hAB00_0000});
    end
    wait_drain();

    // Pointer wrap: last grant was 2, harts 0 and 2 request
    @(negedge clk);
    mem_waits    = 0;
    mem_fixed_en = 1'b0;
    set_req(0, 1'b0, 32'h40, 32'h0, 4'hF);
    set_req(2, 1'b0, 32'h80, 32'h0, 4'hF);
    #1 chk("wrap_grant0", 64'(o_req_ready), 64'b001);
    push(3'b001, 32'h5A5A_0040, cyc + 2);
    @(negedge clk);
    clr_req(0);
    #1 chk("wrap_busy_noready", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    #1 chk("wrap_grant2", 64'(o_req_ready), 64'b100);
    push(3'b100, 32'h5A5A_0080, cyc + 2);
    @(negedge clk);
    clr_req(2);
    wait_drain();

    // Contention from reset: all three continuously valid
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'(16 * (k + 1)), 32'h0, 4'hF);
    for (int n = 0; n < 6; n++) begin
      #1 chk("contend_grant", 64'(o_req_ready), 64'(cont_grant[n]));
      push(cont_grant[n], cont_rdata[n % 3], cyc + 2);
      @(negedge clk);
      #1 chk("contend_busy", 64'(o_req_ready), 64'd0);
      if (n == 5) req_valid = '0;
      @(negedge clk);
    end
    wait_drain();

    // Reset mid-BUSY: first make hart 0 the last grant
    @(negedge clk);
    set_req(0, 1'b0, 32'h44, 32'h0, 4'hF);
    #1 chk("pre_rst_grant0", 64'(o_req_ready), 64'b001);
    push(3'b001, 32'h5A5A_0044, cyc + 2);
    @(negedge clk);
    clr_req(0);
    wait_drain();
    @(negedge clk);
    mem_waits = 5;
    set_req(1, 1'b0, 32'h48, 32'h0, 4'hF);
    #1 chk("rst_load_grant", 64'(o_req_ready), 64'b010);
    @(negedge clk);
    clr_req(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_ren", 64'(o_mem_ren), 64'd0);
    chk("rst_no_rsp", 64'(o_rsp_valid), 64'd0);
    rst       = 1'b0;
    mem_waits = 0;
    set_req(0, 1'b0, 32'h4C, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h50, 32'h0, 4'hF);
    #1 chk("rst_prio_hart0", 64'(o_req_ready), 64'b001);
    push(3'b001, 32'h5A5A_004C, cyc + 2);
    @(negedge clk);
    clr_req(0);
    @(negedge clk);
    #1 chk("rst_then_hart1", 64'(o_req_ready), 64'b010);
    push(3'b010, 32'h5A5A_0050, cyc + 2);
    @(negedge clk);
    clr_req(1);
    wait_drain();

    // Idle noise: completion strobes with nothing outstanding
    @(negedge clk);
    noise = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noise_idle_outputs", 64'({o_rsp_valid, o_mem_ren, o_mem_wen}), 64'd0);
    end
    noise = 1'b0;
    set_req(2, 1'b1, 32'h60, 32'h1234_5678, 4'hF);
    #1 chk("noise_still_idle", 64'(o_req_ready), 64'b100);
    push(3'b100, 32'h0, cyc + 2);
    @(negedge clk);
    clr_req(2);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
